// File: rtl/math_multiplier_booth_radix_4_seq.sv
// rtl/math_multiplier_booth_radix_4_seq.sv - sequential radix-4 Booth multiplier, one digit per clock
// Define MATH_BOOTH_UNSIGNED_EN to add i_unsigned (zero-extended operands, one extra digit).
module math_multiplier_booth_radix_4_seq #(
   parameter int N = 8
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_valid,
   output logic           o_ready,
   input  logic [N-1:0]   i_multiplicand,
   input  logic [N-1:0]   i_multiplier,
`ifdef MATH_BOOTH_UNSIGNED_EN
   input  logic           i_unsigned,
`endif
   output logic           o_valid,
   input  logic           i_ready,
   output logic [2*N-1:0] o_product,
   output logic           o_busy
);

`ifdef MATH_BOOTH_UNSIGNED_EN
   localparam int W = N + 1;
`else
   localparam int W = N;
`endif
   localparam int K  = (W + 1) / 2;
   localparam int YW = 2 * K;
   localparam int PW = 2 * N;
   localparam int CW = $clog2(K + 1);
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   mcand_q, mcand_d;
   logic [YW-1:0]   mplier_q, mplier_d;
   logic            prev_q, prev_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ready_q, busy_q, valid_q;

   logic            ext_zero;
   logic [PW-1:0]   mcand_ext;
   logic [YW-1:0]   mplier_ext;
   logic [PW-1:0]   addend;

`ifdef MATH_BOOTH_UNSIGNED_EN
   assign ext_zero = i_unsigned;
`else
   assign ext_zero = 1'b0;
`endif

   // Extension bit is the operand sign, or zero for unsigned operands.
   always_comb begin
      mcand_ext  = PW'($signed({i_multiplicand[N-1] & ~ext_zero, i_multiplicand}));
      mplier_ext = YW'($signed({i_multiplier[N-1] & ~ext_zero, i_multiplier}));
   end

   // mcand_q is pre-shifted by 2i, so the digit weight is already applied.
   always_comb begin
      addend = '0;
      unique case ({mplier_q[1:0], prev_q})
         3'b001, 3'b010: addend = mcand_q;
         3'b011:         addend = mcand_q << 1;
         3'b100:         addend = -(mcand_q << 1);
         3'b101, 3'b110: addend = -mcand_q;
         default:        addend = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prev_d   = prev_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               state_d  = S_BUSY;
               mcand_d  = mcand_ext;
               mplier_d = mplier_ext;
               prev_d   = 1'b0;
               acc_d    = '0;
               cnt_d    = '0;
            end
         end
         S_BUSY: begin
            acc_d    = acc_q + addend;
            mcand_d  = mcand_q << 2;
            mplier_d = mplier_q >> 2;
            prev_d   = mplier_q[1];
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (i_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         prev_q   <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prev_q   <= prev_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         ready_q  <= (state_d == S_IDLE);
         busy_q   <= (state_d == S_BUSY);
         valid_q  <= (state_d == S_DONE);
      end
   end

   assign o_ready   = ready_q;
   assign o_busy    = busy_q;
   assign o_valid   = valid_q;
   assign o_product = acc_q;

endmodule
